phase_timer: RTL

- Per-direction phase executor that sits directly downstream of the intersection sequencer, one instance per approach (sud, est, vest, nord, pietoni).
- Consumes the sequencer's enable_X / clear_X / service controls.
- Times a green-then-yellow phase from an internal seconds prescaler and drives the red/yellow/green lamps.
- Returns done_X to the sequencer when its phase completes.

---
 rtl/phase_timer_if.sv | 23 ++
 rtl/phase_timer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/phase_timer_if.sv
// Control/lamp bundle between the intersection sequencer and one phase_timer.
// master: sequencer side; slave: phase_timer side.
interface phase_timer_if;
    logic       enable;
    logic       clear;
    logic       service;
    logic       lamp_red;
    logic       lamp_yellow;
    logic       lamp_green;
    logic       done;
    logic       busy;
    logic [7:0] sec_left;

    modport master (
        output enable, clear, service,
        input  lamp_red, lamp_yellow, lamp_green, done, busy, sec_left
    );

    modport slave (
        input  enable, clear, service,
        output lamp_red, lamp_yellow, lamp_green, done, busy, sec_left
    );
endinterface

// File: rtl/phase_timer.sv
// Per-approach phase executor: times green then yellow from a seconds prescaler,
// drives the lamps and reports done back to the sequencer. Service mode flashes yellow.
// Optional macro PHASE_TIMER_BLINK_EN blinks green during the last BLINK_SEC seconds.
module phase_timer #(
    parameter int unsigned DIV_FACTOR = 10,
    parameter int unsigned GREEN_SEC  = 5,
    parameter int unsigned YELLOW_SEC = 2,
    parameter int unsigned BLINK_SEC  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    phase_timer_if.slave  ctrl_io
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StGreen   = 3'd1,
        StYellow  = 3'd2,
        StDone    = 3'd3,
        StService = 3'd4
    } state_e;

    localparam logic [15:0] DivLast    = 16'(DIV_FACTOR - 1);
    localparam logic [7:0]  GreenSec   = 8'(GREEN_SEC);
    localparam logic [7:0]  GreenLast  = 8'(GREEN_SEC - 1);
    localparam logic [7:0]  YellowSec  = 8'(YELLOW_SEC);
    localparam logic [7:0]  YellowLast = 8'(YELLOW_SEC - 1);
`ifdef PHASE_TIMER_BLINK_EN
    localparam logic [15:0] DivHalf    = 16'(DIV_FACTOR / 2);
    localparam logic [7:0]  BlinkStart = 8'(GREEN_SEC - BLINK_SEC);
`endif

    state_e      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  sec_q, sec_d;
    logic        flash_q, flash_d;
    logic        running;
    logic        tick;

    assign running = (state_q == StGreen) || (state_q == StYellow) || (state_q == StService);
    assign tick    = running && (presc_q == DivLast);

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            presc_q <= '0;
            sec_q   <= '0;
            flash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            flash_q <= flash_d;
        end
    end

    // Next state: service > clear > enable in every state; illegal codes fall back to idle.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        flash_d = flash_q;
        presc_d = running ? (tick ? 16'd0 : presc_q + 16'd1) : 16'd0;

        case (state_q)
            StIdle: begin
                if (ctrl_io.service) begin
                    state_d = StService;
                    flash_d = 1'b1;
                end else if (ctrl_io.enable) begin
                    state_d = StGreen;
                    sec_d   = '0;
                end
            end
            StGreen: begin
                if (ctrl_io.service) begin
                    state_d = StService;
                    flash_d = 1'b1;
                    sec_d   = '0;
                end else if (ctrl_io.clear) begin
                    state_d = StIdle;
                    sec_d   = '0;
                end else if (tick) begin
                    if (sec_q == GreenLast) begin
                        state_d = StYellow;
                        sec_d   = '0;
                    end else begin
                        sec_d = sec_q + 8'd1;
                    end
                end
            end
            StYellow: begin
                if (ctrl_io.service) begin
                    state_d = StService;
                    flash_d = 1'b1;
                    sec_d   = '0;
                end else if (ctrl_io.clear) begin
                    state_d = StIdle;
                    sec_d   = '0;
                end else if (tick) begin
                    if (sec_q == YellowLast) begin
                        state_d = StDone;
                        sec_d   = '0;
                    end else begin
                        sec_d = sec_q + 8'd1;
                    end
                end
            end
            StDone: begin
                if (ctrl_io.service) begin
                    state_d = StService;
                    flash_d = 1'b1;
                end else if (ctrl_io.clear) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (!ctrl_io.service) begin
                    state_d = StIdle;
                    flash_d = 1'b0;
                end else if (tick) begin
                    flash_d = ~flash_q;
                end
            end
            default: begin
                state_d = StIdle;
                sec_d   = '0;
                flash_d = 1'b0;
            end
        endcase

        // Every interval starts from a fresh second.
        if (state_d != state_q) begin
            presc_d = '0;
        end
    end

    // Lamp/status decode from registered state only.
    always_comb begin
        ctrl_io.lamp_red    = 1'b0;
        ctrl_io.lamp_yellow = 1'b0;
        ctrl_io.lamp_green  = 1'b0;
        ctrl_io.done        = 1'b0;
        ctrl_io.busy        = 1'b0;
        ctrl_io.sec_left    = 8'd0;
        case (state_q)
            StGreen: begin
                ctrl_io.lamp_green = 1'b1;
`ifdef PHASE_TIMER_BLINK_EN
                if ((BLINK_SEC != 0) && (sec_q >= BlinkStart)) begin
                    ctrl_io.lamp_green = (presc_q < DivHalf);
                end
`endif
                ctrl_io.busy     = 1'b1;
                ctrl_io.sec_left = GreenSec - sec_q;
            end
            StYellow: begin
                ctrl_io.lamp_yellow = 1'b1;
                ctrl_io.busy        = 1'b1;
                ctrl_io.sec_left    = YellowSec - sec_q;
            end
            StDone: begin
                ctrl_io.lamp_red = 1'b1;
                ctrl_io.done     = 1'b1;
            end
            StService: begin
                ctrl_io.lamp_yellow = flash_q;
            end
            default: begin
                ctrl_io.lamp_red = 1'b1;
            end
        endcase
    end

endmodule
